ifmap_row_feeder: RTL and testbench
===================================

IFMAP_ROW_FEEDER -- requirements
Module: ifmap_row_feeder

Interface
REQ-001 Parameter IFMap_WIDTH, default 16: pixel data width.
REQ-002 Parameter LEN_WIDTH, default 4: width of row_len and num_rows.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rstn  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle pulse that starts a job; sampled only in IDLE.
REQ-006 row_len  in  LEN_WIDTH  pixels per row; captured on an accepted start.
REQ-007 num_rows  in  LEN_WIDTH  rows per job; captured on an accepted start.
REQ-008 in_data  in  IFMap_WIDTH  raw signed pixel from the upstream reader.
REQ-009 in_valid  in  1  in_data valid.
REQ-010 in_ready  out  1  feeder accepts in_data this cycle.
REQ-011 IFMap  out  IFMap_WIDTH+2  tagged word to the conv IFMap buffer; {start_of_row, end_of_row, pixel}.
REQ-012 IF_buff_wen  out  1  IFMap holds a valid word.
REQ-013 IF_buff_ready  in  1  conv IFMap buffer accepts a word this cycle.
REQ-014 busy  out  1  job in progress.
REQ-015 done  out  1  one-cycle pulse at job completion.

Function
REQ-016 The FSM SHALL have three states: IDLE, STREAM and DONE.
REQ-017 IDLE -> STREAM when start=1, row_len!=0 and num_rows!=0; the feeder captures row_len and num_rows and clears the column and row counters.
REQ-018 A start with row_len=0 or num_rows=0 SHALL go IDLE -> DONE, with no word emitted.
REQ-019 An input handshake occurs when in_valid=1 and in_ready=1; an output transfer occurs when IF_buff_wen=1 and IF_buff_ready=1.
REQ-020 in_ready = (state==STREAM) and (not all pixels accepted) and (IF_buff_wen=0 or IF_buff_ready=1), so the output register is one entry and runs at full throughput.
REQ-021 On an input handshake, in_data SHALL be registered to IFMap[IFMap_WIDTH-1:0] with IF_buff_wen=1 on the next cycle (latency 1).
REQ-022 Tag bits: IFMap[IFMap_WIDTH+1]=1 when column==0; IFMap[IFMap_WIDTH]=1 when column==row_len-1; a row with row_len=1 gets tag 2'b11; middle pixels get 2'b00.
REQ-023 The column counter SHALL increment on each input handshake and wrap to 0 after row_len-1; the row counter increments on that wrap.
REQ-024 After row num_rows-1 wraps, in_ready SHALL stay 0.
REQ-025 When the last word transfers out, STREAM -> DONE.
REQ-026 IF_buff_wen=1 with IF_buff_ready=0 SHALL hold IFMap and IF_buff_wen stable.
REQ-027 If a transfer and an input handshake occur in the same cycle, the register loads the new word and IF_buff_wen stays 1.
REQ-028 The DONE state SHALL last one cycle, with done=1, and then go to IDLE.
REQ-029 busy=1 in STREAM and DONE.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 Pixel data SHALL pass through unmodified (no sign change and no truncation).
REQ-032 row_len and num_rows changing mid-job SHALL have no effect.

Reset
REQ-033 With rstn=0, the FSM SHALL go to IDLE (immediately, asynchronously) and clear the counters, IFMap=0, IF_buff_wen=0, in_ready=0, busy=0 and done=0.
REQ-034 Reset mid-job SHALL discard the job, including a held output word; after rstn rises, the first start begins a clean job.

Verification
REQ-035 Single row: row_len=10, num_rows=1, IF_buff_ready=1, pixels 88,146,78,-129,-123,-30,68,-61,28,-137 -> IFMap sequence {2'b10,88},{2'b00,146},...,{2'b01,-137}; each word one cycle after its handshake; done one cycle after the last transfer.
REQ-036 Backpressure: row_len=4, IF_buff_ready low for 3 cycles during word 2 -> IFMap held stable, in_ready=0, no pixel lost or duplicated, order preserved.
REQ-037 Multi-row: row_len=3, num_rows=2, pixels 1..6 -> tags 10,00,01,10,00,01; in_ready=0 after the 6th handshake.
REQ-038 Degenerate: row_len=1, num_rows=3 -> three words all tagged 2'b11; then row_len=0 -> done in the cycle after start, no IF_buff_wen.
REQ-039 Start during busy: second start mid-job ignored; job completes with the original row_len.
REQ-040 Reset mid-job: rstn low after 2 of 5 pixels -> all outputs 0 at once; the new job after reset emits a start-of-row tag on its first word.

Source files
------------

// File: rtl/ifmap_row_feeder.sv
// Streams a job of num_rows x row_len pixels into the conv IFMap buffer,
// tagging each word with start-of-row / end-of-row bits through a one-entry output register.
module ifmap_row_feeder #(
    parameter int unsigned IFMap_WIDTH = 16,
    parameter int unsigned LEN_WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     row_len,
    input  logic [LEN_WIDTH-1:0]     num_rows,
    input  logic [IFMap_WIDTH-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [IFMap_WIDTH+1:0]   IFMap,
    output logic                     IF_buff_wen,
    input  logic                     IF_buff_ready,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] rows_q;
    logic [LEN_WIDTH-1:0] col;
    logic [LEN_WIDTH-1:0] row;
    logic                 all_in;

    logic in_hs;
    logic out_xfer;
    logic first_col;
    logic last_col;
    logic last_row;

    // Output register can take a new word when empty or draining this cycle.
    assign in_ready  = (state == STREAM) && !all_in && (!IF_buff_wen || IF_buff_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_xfer  = IF_buff_wen && IF_buff_ready;
    assign first_col = (col == '0);
    assign last_col  = (col == len_q - LEN_WIDTH'(1));
    assign last_row  = (row == rows_q - LEN_WIDTH'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            len_q       <= '0;
            rows_q      <= '0;
            col         <= '0;
            row         <= '0;
            all_in      <= 1'b0;
            IFMap       <= '0;
            IF_buff_wen <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if ((row_len != '0) && (num_rows != '0)) begin
                            state  <= STREAM;
                            len_q  <= row_len;
                            rows_q <= num_rows;
                            col    <= '0;
                            row    <= '0;
                            all_in <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                STREAM: begin
                    if (in_hs) begin
                        IFMap       <= {first_col, last_col, in_data};
                        IF_buff_wen <= 1'b1;
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                all_in <= 1'b1;
                            end else begin
                                row <= row + LEN_WIDTH'(1);
                            end
                        end else begin
                            col <= col + LEN_WIDTH'(1);
                        end
                    end else if (out_xfer) begin
                        IF_buff_wen <= 1'b0;
                    end
                    // Last word leaves only after every pixel has been accepted.
                    if (all_in && out_xfer) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifmap_row_feeder.sv
// Scoreboard bench for ifmap_row_feeder: directed jobs push expected tagged words,
// a negedge monitor pops and compares on every output transfer.
module tb_ifmap_row_feeder;

    localparam int unsigned W  = 16;
    localparam int unsigned LW = 4;

    logic            clk;
    logic            rstn;
    logic            start;
    logic [LW-1:0]   row_len;
    logic [LW-1:0]   num_rows;
    logic [W-1:0]    in_data;
    logic            in_valid;
    logic            in_ready;
    logic [W+1:0]    IFMap;
    logic            IF_buff_wen;
    logic            IF_buff_ready;
    logic            busy;
    logic            done;

    logic [W+1:0] sb[$];
    int n_vec;
    int n_fail;

    ifmap_row_feeder #(.IFMap_WIDTH(W), .LEN_WIDTH(LW)) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .row_len(row_len),
        .num_rows(num_rows),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .IFMap(IFMap),
        .IF_buff_wen(IF_buff_wen),
        .IF_buff_ready(IF_buff_ready),
        .busy(busy),
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && IF_buff_wen === 1'b1 && IF_buff_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL spurious_word: got %h expected no word at %0t", IFMap, $time);
                end else begin
                    check("word", 32'(IFMap), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic start_job(input int len, input int rows);
        row_len  = LW'(len);
        num_rows = LW'(rows);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input int d, input logic [1:0] tag);
        logic hs;
        int   n;
        hs = 1'b0;
        n  = 0;
        sb.push_back({tag, W'(d)});
        in_data  = W'(d);
        in_valid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!hs) begin
            n_vec++;
            n_fail++;
            $display("FAIL handshake_timeout: got no in_ready expected handshake for %0d", d);
        end else begin
            check("latency_wen", 32'(IF_buff_wen), 32'd1);
            check("latency_word", 32'(IFMap), 32'({tag, W'(d)}));
        end
    endtask

    task automatic wait_done(input string name);
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = done;
            n++;
        end
        check(name, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    int          px10[10] = '{88, 146, 78, -129, -123, -30, 68, -61, 28, -137};
    logic [1:0]  tg6[6]   = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};

    initial begin
        n_vec         = 0;
        n_fail        = 0;
        rstn          = 1'b0;
        start         = 1'b0;
        row_len       = '0;
        num_rows      = '0;
        in_data       = '0;
        in_valid      = 1'b0;
        IF_buff_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ifmap", 32'(IFMap), 32'd0);
        check("rst_wen", 32'(IF_buff_wen), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single row of 10 signed pixels, buffer always ready
        start_job(10, 1);
        check("busy_stream", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++)
            send(px10[i], (i == 0) ? 2'b10 : ((i == 9) ? 2'b01 : 2'b00));
        @(negedge clk);
        check("done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("done_timing", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("after_done_busy", 32'(busy), 32'd0);
        check("after_done_pulse", 32'(done), 32'd0);

        // Backpressure on word 2 of a 4-pixel row
        start_job(4, 1);
        send(5, 2'b10);
        send(-6, 2'b00);
        IF_buff_ready = 1'b0;
        in_valid      = 1'b1;
        in_data       = W'(7);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_wen", 32'(IF_buff_wen), 32'd1);
            check("bp_hold", 32'(IFMap), 32'({2'b00, W'(-6)}));
            @(posedge clk);
            #1;
        end
        IF_buff_ready = 1'b1;
        in_valid      = 1'b0;
        send(7, 2'b00);
        send(-8, 2'b01);
        wait_done("bp_done");

        // Two rows of three
        start_job(3, 2);
        for (int i = 0; i < 6; i++)
            send(i + 1, tg6[i]);
        in_valid = 1'b1;
        in_data  = W'(99);
        @(negedge clk);
        check("mr_in_ready_closed", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_done("mr_done");

        // One-pixel rows, then an empty job
        start_job(1, 3);
        send(-1, 2'b11);
        send(2, 2'b11);
        send(-3, 2'b11);
        wait_done("r1_done");
        start_job(0, 2);
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        check("empty_wen", 32'(IF_buff_wen), 32'd0);
        @(posedge clk);
        #1;
        check("empty_busy", 32'(busy), 32'd0);

        // Second start mid-job must not re-capture lengths
        start_job(3, 1);
        send(10, 2'b10);
        start_job(5, 2);
        send(11, 2'b00);
        send(12, 2'b01);
        wait_done("restart_ignored_done");

        // Reset mid-job with a held output word
        start_job(5, 1);
        send(100, 2'b10);
        send(101, 2'b00);
        IF_buff_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_ifmap", 32'(IFMap), 32'd0);
        check("mid_rst_wen", 32'(IF_buff_wen), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rstn          = 1'b1;
        IF_buff_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_wen", 32'(IF_buff_wen), 32'd0);
        start_job(2, 1);
        send(7, 2'b10);
        send(8, 2'b01);
        wait_done("post_rst_done");

        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
